// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the instruction-class performance monitor.
// The state enum, class indices and default halt opcode live here so the bench and RTL agree.
package perf_monitor_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} state_t;

    localparam int ARITH = 0;
    localparam int LOGIC = 1;
    localparam int MEM   = 2;
    localparam int CTRL  = 3;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b010001;

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/perf_monitor.sv
// Per-class retirement and stall counters; after a halt opcode and a fixed drain,
// streams the counts, derived cycle totals and the register file over valid/ready.
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int         N_CLASS      = 4,
    parameter int         CNT_W        = 32,
    parameter int         N_REGS       = 32,
    parameter logic [5:0] HALT_OPCODE  = HALT_OPCODE_DEF,
    parameter int         DRAIN_CYCLES = 6,
    localparam int        CLS_W        = $clog2(N_CLASS),
    localparam int        RA_W         = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inst_valid,
    input  logic [CLS_W-1:0] inst_class,
    input  logic [31:0]      inst_word,
    input  logic             stall_fwd,
    input  logic             stall_nofwd,
    output logic [RA_W-1:0]  reg_rd_addr,
    input  logic [CNT_W-1:0] reg_rd_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [CNT_W-1:0] dump_data,
    output logic             dump_last,
    output logic             halted,
    output logic [CNT_W-1:0] total_inst
);

    localparam int N_WORDS  = N_CLASS + 5 + N_REGS;
    localparam int IDX_W    = $clog2(N_WORDS);
    localparam int REG_BASE = N_CLASS + 5;
    localparam int DR_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int SUM_W    = CNT_W + $clog2(N_CLASS + 1) + 2;
    localparam int NC       = N_CLASS + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t                   state, state_nx;
    logic [IDX_W-1:0]         idx, idx_nx, reg_off;
    logic [DR_W-1:0]          drain, drain_nx;
    logic                     halted_nx;
    logic                     is_halt, counting;
    logic [NC-1:0]            inc;
    logic [NC-1:0][CNT_W-1:0] cnt;
    logic [SUM_W-1:0]         cls_sum, cyc_nf_sum, cyc_f_sum;
    logic [CNT_W-1:0]         cyc_nf, cyc_f;
    logic                     unused;

    assign unused   = ^inst_word[25:0];
    assign is_halt  = inst_valid && (inst_word[31:26] == HALT_OPCODE);
    assign counting = (state == RUN) || (state == DRAIN);

    // Slots 0..N_CLASS-1 are classes, N_CLASS is stall_nofwd, N_CLASS+1 is stall_fwd.
    always_comb begin
        inc = '0;
        for (int i = 0; i < N_CLASS; i++)
            inc[i] = (state == RUN) && inst_valid && !is_halt && (inst_class == CLS_W'(i));
        inc[N_CLASS]   = counting && stall_nofwd;
        inc[N_CLASS+1] = counting && stall_fwd;
    end

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (reset),
            .clr (clr),
            .inc (inc[g]),
            .cnt (cnt[g])
        );
    end

    function automatic logic [CNT_W-1:0] clip(input logic [SUM_W-1:0] x);
        return (x > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : x[CNT_W-1:0];
    endfunction

    // Sums are formed wide and clipped so saturated inputs never wrap the totals.
    always_comb begin
        cls_sum = '0;
        for (int i = 0; i < N_CLASS; i++)
            cls_sum = cls_sum + SUM_W'(cnt[i]);
    end

    assign total_inst = clip(cls_sum);
    assign cyc_nf_sum = SUM_W'(total_inst) + SUM_W'(DRAIN_CYCLES) + SUM_W'(cnt[N_CLASS]);
    assign cyc_f_sum  = SUM_W'(total_inst) + SUM_W'(DRAIN_CYCLES) + SUM_W'(cnt[N_CLASS+1]);
    assign cyc_nf     = clip(cyc_nf_sum);
    assign cyc_f      = clip(cyc_f_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            idx    <= '0;
            drain  <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            drain  <= drain_nx;
            halted <= halted_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        drain_nx  = drain;
        halted_nx = halted;
        if (clr) begin
            state_nx  = RUN;
            idx_nx    = '0;
            drain_nx  = '0;
            halted_nx = 1'b0;
        end else begin
            case (state)
                RUN: if (is_halt) begin
                    state_nx  = DRAIN;
                    drain_nx  = DR_W'(DRAIN_CYCLES - 1);
                    halted_nx = 1'b1;
                end
                DRAIN: if (drain == '0) begin
                    state_nx = DUMP;
                    idx_nx   = '0;
                end else begin
                    drain_nx = drain - 1'b1;
                end
                DUMP: if (dump_ready) begin
                    if (idx == IDX_W'(N_WORDS - 1))
                        state_nx = DONE;
                    else
                        idx_nx = idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dump_valid  = (state == DUMP);
    assign dump_last   = dump_valid && (idx == IDX_W'(N_WORDS - 1));
    assign reg_off     = idx - IDX_W'(REG_BASE);
    assign reg_rd_addr = (dump_valid && (idx >= IDX_W'(REG_BASE))) ? RA_W'(reg_off) : '0;

    always_comb begin
        dump_data = '0;
        if (dump_valid) begin
            if (idx >= IDX_W'(REG_BASE))
                dump_data = reg_rd_data;
            else if (idx == IDX_W'(N_CLASS))
                dump_data = total_inst;
            else if (idx == IDX_W'(N_CLASS + 1))
                dump_data = cnt[N_CLASS];
            else if (idx == IDX_W'(N_CLASS + 2))
                dump_data = cnt[N_CLASS+1];
            else if (idx == IDX_W'(N_CLASS + 3))
                dump_data = cyc_nf;
            else if (idx == IDX_W'(N_CLASS + 4))
                dump_data = cyc_f;
            else
                for (int i = 0; i < N_CLASS; i++)
                    if (idx == IDX_W'(i))
                        dump_data = cnt[i];
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Random and directed stimulus on two monitors (32-bit and 4-bit counters) sharing inputs,
// checked against a count-and-clip reference model of the dump contents.
module tb_perf_monitor;

    localparam int NC = 4;
    localparam int NR = 32;
    localparam int DC = 6;
    localparam int NW = NC + 5 + NR;
    localparam logic [5:0] HALT = 6'b010001;

    logic        clk = 1'b0;
    logic        reset, clr, inst_valid, stall_fwd, stall_nofwd, dump_ready;
    logic [1:0]  inst_class;
    logic [31:0] inst_word;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] rd_a, data_a, tot_a;
    logic [3:0]  rd_b, data_b, tot_b;
    logic        valid_a, last_a, halted_a, valid_b, last_b, halted_b;

    assign rd_a = 32'hA500_0000 + 32'(addr_a) * 32'd3;
    assign rd_b = 4'(addr_b) ^ 4'd5;

    perf_monitor #(.CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .inst_valid(inst_valid), .inst_class(inst_class),
        .inst_word(inst_word), .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd),
        .reg_rd_addr(addr_a), .reg_rd_data(rd_a), .dump_valid(valid_a), .dump_ready(dump_ready),
        .dump_data(data_a), .dump_last(last_a), .halted(halted_a), .total_inst(tot_a));

    perf_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .inst_valid(inst_valid), .inst_class(inst_class),
        .inst_word(inst_word), .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd),
        .reg_rd_addr(addr_b), .reg_rd_data(rd_b), .dump_valid(valid_b), .dump_ready(dump_ready),
        .dump_data(data_b), .dump_last(last_b), .halted(halted_b), .total_inst(tot_b));

    always #5 clk = ~clk;

    int     n_chk, n_fail;
    longint m_cls[NC];
    longint m_nf, m_fwd;
    int     ph;       // 0 run, 1 drain, 2 dump, 3 done
    int     m_drain;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    // Expected dump word k for a monitor with w-bit counters.
    function automatic longint exp_word(input int k, input int w);
        longint tot = 0;
        int     a;
        for (int i = 0; i < NC; i++) tot += sat(m_cls[i], w);
        tot = sat(tot, w);
        if (k < NC) return sat(m_cls[k], w);
        case (k - NC)
            0: return tot;
            1: return sat(m_nf, w);
            2: return sat(m_fwd, w);
            3: return sat(tot + DC + sat(m_nf, w), w);
            4: return sat(tot + DC + sat(m_fwd, w), w);
            default: begin
                a = k - NC - 5;
                return (w == 32) ? (longint'(32'hA500_0000) + a * 3) : ((a ^ 5) & 15);
            end
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_cls[i] = 0;
        m_nf = 0; m_fwd = 0; ph = 0; m_drain = 0;
    endtask

    task automatic set_inputs(input bit v, input int cls, input bit hlt, input bit sf, input bit snf);
        logic [5:0] op;
        op = 6'($urandom);
        if (op == HALT) op = 6'h00;
        inst_valid  = v;
        inst_class  = 2'(cls);
        inst_word   = {hlt ? HALT : op, 26'($urandom)};
        stall_fwd   = sf;
        stall_nofwd = snf;
    endtask

    // One clock of stimulus, applied at negedge; model updated for the upcoming edge.
    task automatic step(input bit v, input int cls, input bit hlt, input bit sf, input bit snf);
        set_inputs(v, cls, hlt, sf, snf);
        if (!clr && !reset) begin
            if (ph == 0) begin
                if (v && !hlt) m_cls[cls]++;
                if (sf) m_fwd++;
                if (snf) m_nf++;
                if (v && hlt) begin ph = 1; m_drain = DC; end
            end else if (ph == 1) begin
                if (sf) m_fwd++;
                if (snf) m_nf++;
                m_drain--;
                if (m_drain == 0) ph = 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_rand(input int n, input int pv, input int ps);
        for (int i = 0; i < n; i++)
            step($urandom_range(99) < pv, $urandom_range(3), 1'b0,
                 $urandom_range(99) < ps, $urandom_range(99) < ps);
    endtask

    task automatic halt_drain(input int cls, input int nd, input bit rnd);
        step(1'b1, cls, 1'b1, rnd & $urandom_range(1), rnd & $urandom_range(1));
        chk("halted_a", halted_a, 1);
        chk("halted_b", halted_b, 1);
        chk("dv_after_halt", valid_a, 0);
        for (int i = 0; i < nd; i++) begin
            step(rnd & $urandom_range(1), $urandom_range(3), rnd && ($urandom_range(3) == 0),
                 rnd & $urandom_range(1), rnd & $urandom_range(1));
            if (i < DC - 1) chk("dv_in_drain", valid_a, 0);
        end
        if (nd == DC) begin
            chk("dv_dump_a", valid_a, 1);
            chk("dv_dump_b", valid_b, 1);
        end
    endtask

    // mode 0: always ready, 1: toggling ready, 2: random ready. Stops early at stop_at.
    task automatic dump(input int mode, input int stop_at);
        int idx = 0;
        int bud = 0;
        bit tg = 1'b1;
        bit rdy;
        while (idx < NW && idx != stop_at && bud < 2000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tg : 1'($urandom_range(1));
            tg = ~tg;
            dump_ready = rdy;
            set_inputs($urandom_range(1), $urandom_range(3), $urandom_range(1),
                       $urandom_range(1), $urandom_range(1));
            chk("dump_valid_a", valid_a, 1);
            chk("dump_data_a", data_a, exp_word(idx, 32));
            chk("dump_last_a", last_a, idx == NW - 1);
            chk("rd_addr_a", addr_a, (idx >= NC + 5) ? idx - NC - 5 : 0);
            chk("dump_valid_b", valid_b, 1);
            chk("dump_data_b", data_b, exp_word(idx, 4));
            chk("dump_last_b", last_b, idx == NW - 1);
            if (rdy) idx++;
            @(posedge clk);
            @(negedge clk);
            bud++;
        end
        dump_ready = 1'b0;
        if (bud >= 2000) chk("dump_timeout", 0, 1);
        if (stop_at < 0) begin
            ph = 3;
            chk("words_accepted", idx, NW);
            chk("done_valid", valid_a, 0);
            chk("done_last", last_a, 0);
            chk("done_halted", halted_a, 1);
            chk("done_data", data_a, 0);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b1, 0, 1'b0, 1'b1, 1'b1);
        clr = 1'b0;
        model_clear();
        chk("clr_halted", halted_a, 0);
        chk("clr_valid", valid_a, 0);
        chk("clr_total_a", tot_a, 0);
        chk("clr_total_b", tot_b, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid_a"}, valid_a, 0);
        chk({tag, "_valid_b"}, valid_b, 0);
        chk({tag, "_halted"}, halted_a, 0);
        chk({tag, "_last"}, last_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_total_a"}, tot_a, 0);
        chk({tag, "_total_b"}, tot_b, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1; clr = 1'b0; dump_ready = 1'b0;
        set_inputs(1'b0, 0, 1'b0, 1'b0, 1'b0);
        model_clear();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // 3 arith, 2 logic, 4 mem, 1 ctrl, then halt tagged as ctrl
        repeat (3) step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        chk("total_live", tot_a, 10);
        halt_drain(3, DC, 1'b0);
        chk("total_after_halt", tot_a, 10);
        dump(0, -1);
        repeat (3) step(1'b1, 0, 1'b1, 1'b1, 1'b1);
        chk("frozen_total", tot_a, exp_word(NC, 32));
        chk("frozen_valid", valid_a, 0);
        do_clr();

        // stalls with toggling ready
        for (int i = 0; i < 10; i++) step(1'b1, i % 4, 1'b0, i < 2, i < 5);
        halt_drain(0, DC, 1'b0);
        dump(1, -1);
        do_clr();

        // 4-bit counters saturate
        repeat (20) step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        halt_drain(1, DC, 1'b0);
        chk("sat_word0_b", data_b, 15);
        chk("sat_total_b", tot_b, 15);
        dump(2, -1);
        do_clr();

        // clr on dump word 12 with junk inputs, then clr against a retirement in RUN
        run_rand(30, 70, 30);
        halt_drain($urandom_range(3), DC, 1'b1);
        dump(0, 12);
        do_clr();
        chk("clr_mid_last", last_a, 0);
        chk("clr_mid_addr", addr_a, 0);
        run_rand(15, 70, 30);
        do_clr();
        run_rand(25, 70, 30);
        halt_drain($urandom_range(3), DC, 1'b1);
        dump(2, -1);
        do_clr();

        // random runs
        for (int r = 0; r < 4; r++) begin
            run_rand(40 + $urandom_range(40), $urandom_range(100), $urandom_range(100));
            halt_drain($urandom_range(3), DC, 1'b1);
            dump(2, -1);
            do_clr();
        end

        // reset mid-drain, asynchronously
        run_rand(10, 80, 30);
        halt_drain(3, 2, 1'b1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_drain");
        @(negedge clk);
        reset = 1'b0;
        model_clear();

        // reset mid-dump drops dump_valid without a clock edge
        run_rand(12, 80, 30);
        halt_drain(2, DC, 1'b1);
        dump(0, 5);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_dump");
        @(negedge clk);
        reset = 1'b0;
        model_clear();

        // fresh run after reset
        run_rand(20, 60, 40);
        halt_drain($urandom_range(3), DC, 1'b1);
        dump(1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter N_CLASS, default 4: number of instruction-class counters.
REQ-002 Parameter CNT_W, default 32: width of every counter and of dump_data.
REQ-003 Parameter N_REGS, default 32: architectural registers streamed in the dump.
REQ-004 Parameter HALT_OPCODE, default 6'b010001: opcode (inst_word[31:26]) that halts the monitor.
REQ-005 Parameter DRAIN_CYCLES, default 6: pipeline fill/drain cycles added to cycle totals and waited after halt.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-008 clr  in  1  synchronous clear; same effect as reset on the next edge.
REQ-009 inst_valid  in  1  one instruction retires this cycle.
REQ-010 inst_class  in  $clog2(N_CLASS)  class of retiring instruction (0 arith, 1 logic, 2 mem, 3 ctrl at default).
REQ-011 inst_word  in  32  retiring instruction word.
REQ-012 stall_fwd / stall_nofwd  in  1 each  stall this cycle with / without forwarding.
REQ-013 reg_rd_addr  out  $clog2(N_REGS)  register-file read address; reg_rd_data  in  CNT_W  combinational read data.
REQ-014 dump_valid  out  1; dump_ready  in  1; dump_data  out  CNT_W; dump_last  out  1  dump stream, valid/ready handshake.
REQ-015 halted  out  1  high from halt detection until reset/clr.
REQ-016 total_inst  out  CNT_W  live sum of class counters.

Function
REQ-017 States: RUN, DRAIN, DUMP, DONE; reset state RUN.
REQ-018 RUN: inst_valid with opcode != HALT_OPCODE increments class counter inst_class; out-of-range class ignored.
REQ-019 RUN: inst_valid with opcode == HALT_OPCODE counts in no class, sets halted, loads drain counter with DRAIN_CYCLES, goes to DRAIN next cycle.
REQ-020 stall_fwd and stall_nofwd each increment their own counter in RUN and DRAIN, independently of inst_valid in the same cycle.
REQ-021 All counters saturate at 2^CNT_W-1; no wrap.
REQ-022 DRAIN: retirements ignored; counter decrements each cycle; at zero go to DUMP (exactly DRAIN_CYCLES cycles in DRAIN).
REQ-023 DUMP word order, index 0 up: N_CLASS class counts, total_inst, stall_nofwd count, stall_fwd count, total_inst+DRAIN_CYCLES+stall_nofwd, total_inst+DRAIN_CYCLES+stall_fwd, then registers 0..N_REGS-1; N_CLASS+5+N_REGS words total.
REQ-024 Cycle totals saturate, never wrap.
REQ-025 DUMP: dump_valid high; dump_data stable while dump_valid && !dump_ready; index advances only on dump_valid && dump_ready.
REQ-026 Register words: reg_rd_addr = index-(N_CLASS+5), dump_data = reg_rd_data combinationally; reg_rd_addr is 0 otherwise.
REQ-027 dump_last high exactly on the final word; its accepted handshake goes to DONE.
REQ-028 DONE: dump_valid low, counters frozen, halted high; exit only via reset or clr.
REQ-029 clr in any state (including mid-dump) zeroes all counters, index and halted, returns to RUN; clr wins over a same-cycle retirement or stall.
REQ-030 A second halt opcode after the first has no effect.

Reset
REQ-031 Reset: state RUN, all counters 0, halted 0, dump_valid 0, dump_last 0, dump_data 0, reg_rd_addr 0, total_inst 0.
REQ-032 Reset asserted mid-DUMP aborts the stream immediately; dump_valid deasserts asynchronously.

Structure
REQ-033 Shared package holds the state enum, class-index constants (ARITH, LOGIC, MEM, CTRL) and the default HALT_OPCODE.
REQ-034 Sub-module sat_counter (parametrised width, synchronous clear, increment enable, saturation) is instantiated N_CLASS+2 times.

Verification
REQ-035 3 arith, 2 logic, 4 mem, 1 ctrl, then halt; dump_ready=1 -> words 0..4 = 3,2,4,1,10; halted set; 41 words; dump_last on word 40.
REQ-036 5 stall_nofwd and 2 stall_fwd cycles, 10 instructions, halt -> words 7,8 = 21,18.
REQ-037 dump_ready toggles 1/0 every cycle -> each word held while not ready; no word lost or duplicated; 41 accepted words.
REQ-038 CNT_W=4, 20 arith retirements -> class 0 word = 15 (saturated), no wrap.
REQ-039 clr asserted on dump word 12 -> RUN, all counters 0, halted 0, dump_valid 0 next cycle; fresh run dumps correct values.
REQ-040 Reset asserted mid-DRAIN -> all outputs at reset values immediately; halt opcode with inst_class=3 -> ctrl count unchanged.
